// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: shared state encoding, funct3 codes and legality check for the load/store port.
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } memState_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only have signed-width encodings; unsigned variants exist for loads only.
    function automatic logic is_legal_f3(input logic we, input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (!we && ((f3 == F3_BU) || (f3 == F3_HU)));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores and lane extraction/extension for loads.
//   addrLo     - low two bits of the byte address
//   funct3     - RV32 load/store width/sign code
//   wdata      - right-aligned store data
//   rdata      - raw bus read word
//   wstrb      - byte strobes for the access width/offset
//   wdataRep   - store data replicated across all lanes
//   loadData   - selected lane, sign- or zero-extended
//   misaligned - halfword on odd address or word on non-word address
module mem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [1:0]  addrLo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdataRep,
    output logic [31:0] loadData,
    output logic        misaligned
);

    logic [31:0] lane;

    always_comb begin
        lane       = rdata >> {addrLo, 3'b000};
        misaligned = ((funct3[1:0] == 2'b01) && addrLo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addrLo != 2'b00));
        wstrb      = (funct3[1:0] == 2'b00) ? (4'b0001 << addrLo) :
                     (funct3[1:0] == 2'b01) ? (4'b0011 << addrLo) : 4'b1111;
        wdataRep   = (funct3[1:0] == 2'b00) ? {4{wdata[7:0]}} :
                     (funct3[1:0] == 2'b01) ? {2{wdata[15:0]}} : wdata;
        loadData   = (funct3 == F3_B)  ? {{24{lane[7]}}, lane[7:0]} :
                     (funct3 == F3_BU) ? {24'd0, lane[7:0]} :
                     (funct3 == F3_H)  ? {{16{lane[15]}}, lane[15:0]} :
                     (funct3 == F3_HU) ? {16'd0, lane[15:0]} : rdata;
    end

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: load/store port turning core memory accesses into single valid/ready bus transactions.
//   clk, resetn          - clock; synchronous active-high reset (despite the name)
//   cpu_req/we/addr/...  - access request from the core, sampled only in IDLE
//   cpu_rdata            - extended load data, held until the next load completes
//   cpu_done/err/busy    - completion pulse, error flag with done, not-idle indicator
//   bus_valid/ready      - request handshake; request fields stable while valid
//   bus_addr/we/wstrb/wdata - word-aligned request with byte strobes
//   bus_rvalid/rdata     - read response, honoured only while waiting for it
module mem_port_ctrl
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [2:0]        cpu_funct3,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_busy,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    memState_t         state, nextState;
    logic [ADDR_W-1:0] addrQ;
    logic              weQ;
    logic [31:0]       wdataQ;
    logic [2:0]        f3Q;
    logic              errQ;
    logic [31:0]       rdataQ;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        alignAddr;
    logic [2:0]        alignF3;
    logic [3:0]        wstrb;
    logic [31:0]       wdataRep;
    logic [31:0]       loadData;
    logic              misaligned;
    logic              reqBad;
    logic              expired;
    logic              timedOut;

    // One aligner serves both the IDLE legality check (live request) and
    // the later phases (latched request), so misalignment rules live in one place.
    always_comb begin
        alignAddr = (state == IDLE) ? cpu_addr[1:0] : addrQ[1:0];
        alignF3   = (state == IDLE) ? cpu_funct3 : f3Q;
    end

    mem_lane_align uAlign (
        .addrLo    (alignAddr),
        .funct3    (alignF3),
        .wdata     (wdataQ),
        .rdata     (bus_rdata),
        .wstrb     (wstrb),
        .wdataRep  (wdataRep),
        .loadData  (loadData),
        .misaligned(misaligned)
    );

    assign reqBad   = !is_legal_f3(cpu_we, cpu_funct3) || misaligned;
    // Counter is cleared entering ADDR and shared across ADDR+RESP.
    assign expired  = (TIMEOUT != 0) && (cnt == CNT_LAST);
    assign timedOut = expired && (((state == ADDR) && !bus_ready) ||
                                  ((state == RESP) && !bus_rvalid));

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = cpu_req ? (reqBad ? DONE : ADDR) : IDLE;
            ADDR:    nextState = bus_ready ? (weQ ? DONE : RESP) : (expired ? DONE : ADDR);
            RESP:    nextState = (bus_rvalid || expired) ? DONE : RESP;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state  <= IDLE;
            addrQ  <= '0;
            weQ    <= 1'b0;
            wdataQ <= '0;
            f3Q    <= '0;
            errQ   <= 1'b0;
            rdataQ <= '0;
            cnt    <= '0;
        end else begin
            state <= nextState;
            cnt   <= ((state == ADDR) || (state == RESP)) ? cnt + 1'b1 : '0;
            if ((state == IDLE) && cpu_req) begin
                addrQ  <= cpu_addr;
                weQ    <= cpu_we;
                wdataQ <= cpu_wdata;
                f3Q    <= cpu_funct3;
                errQ   <= reqBad;
                if (reqBad && !cpu_we)
                    rdataQ <= '0;
            end
            if (timedOut) begin
                errQ <= 1'b1;
                if (!weQ)
                    rdataQ <= '0;
            end
            if ((state == RESP) && bus_rvalid)
                rdataQ <= loadData;
        end
    end

    assign cpu_rdata = rdataQ;
    assign cpu_done  = (state == DONE);
    assign cpu_err   = cpu_done && errQ;
    assign cpu_busy  = (state != IDLE);
    assign bus_valid = (state == ADDR);
    assign bus_addr  = bus_valid ? {addrQ[ADDR_W-1:2], 2'b00} : '0;
    assign bus_we    = bus_valid && weQ;
    assign bus_wstrb = bus_we ? wstrb : 4'b0000;
    assign bus_wdata = bus_we ? wdataRep : '0;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed self-checking bench for mem_port_ctrl.
module tb_mem_port_ctrl;
    import rv32_mem_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [2:0]  cpu_funct3 = '0;
    logic        bus_ready = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    logic [31:0] cpu_rdata, bus_addr, bus_wdata;
    logic        cpu_done, cpu_err, cpu_busy, bus_valid, bus_we;
    logic [3:0]  bus_wstrb;

    logic [31:0] tRdata, tAddr, tWdata;
    logic        tDone, tErr, tBusy, tValid, tWe;
    logic [3:0]  tWstrb;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_port_ctrl dut (
        .clk(clk), .resetn(resetn), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    mem_port_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dutT (
        .clk(clk), .resetn(resetn), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
        .cpu_rdata(tRdata), .cpu_done(tDone), .cpu_err(tErr), .cpu_busy(tBusy),
        .bus_valid(tValid), .bus_ready(bus_ready), .bus_addr(tAddr), .bus_we(tWe),
        .bus_wstrb(tWstrb), .bus_wdata(tWdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
        cpu_req    = 1'b1;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_wdata  = wd;
        cpu_funct3 = f3;
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        tick();
        tick();
        total++;
        if ({cpu_done, cpu_err, cpu_busy, bus_valid, bus_we, bus_wstrb} !== 9'd0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0", {cpu_done, cpu_err, cpu_busy, bus_valid, bus_we, bus_wstrb});
        end
        total++;
        if ({cpu_rdata, bus_addr, bus_wdata} !== 96'd0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {cpu_rdata, bus_addr, bus_wdata});
        end
        resetn = 1'b0;
        tick();
        total++;
        if ({cpu_done, cpu_busy, bus_valid} !== 3'd0) begin
            bad++; $display("FAIL reset_release got=%b exp=000", {cpu_done, cpu_busy, bus_valid});
        end
    endtask

    task automatic test_sb();
        bus_ready = 1'b1;
        issue(1'b1, 32'h0000_1003, 32'h0000_00A5, F3_B);
        total++;
        if ({bus_valid, bus_we, bus_addr} !== {1'b1, 1'b1, 32'h0000_1000}) begin
            bad++; $display("FAIL sb_addr got=%b/%b/%h exp=1/1/00001000", bus_valid, bus_we, bus_addr);
        end
        total++;
        if ({bus_wstrb, bus_wdata} !== {4'b1000, 32'hA5A5_A5A5}) begin
            bad++; $display("FAIL sb_data got=%b/%h exp=1000/a5a5a5a5", bus_wstrb, bus_wdata);
        end
        total++;
        if ({cpu_done, cpu_busy} !== 2'b01) begin
            bad++; $display("FAIL sb_early_done got=%b exp=01", {cpu_done, cpu_busy});
        end
        tick();
        total++;
        if ({cpu_done, cpu_err, bus_valid} !== 3'b100) begin
            bad++; $display("FAIL sb_done got=%b exp=100", {cpu_done, cpu_err, bus_valid});
        end
        tick();
        total++;
        if ({cpu_done, cpu_busy} !== 2'b00) begin
            bad++; $display("FAIL sb_idle got=%b exp=00", {cpu_done, cpu_busy});
        end
    endtask

    task automatic test_stores();
        logic [31:0] addrs [5] = '{32'h3002, 32'h3000, 32'h3004, 32'h3001, 32'h3002};
        logic [2:0]  f3s   [5] = '{F3_H, F3_H, F3_W, F3_B, F3_B};
        logic [31:0] wds   [5] = '{32'h1234_BEEF, 32'h0000_7777, 32'hCAFE_F00D, 32'h1234_5678, 32'h0000_005A};
        logic [3:0]  strbs [5] = '{4'b1100, 4'b0011, 4'b1111, 4'b0010, 4'b0100};
        logic [31:0] reps  [5] = '{32'hBEEF_BEEF, 32'h7777_7777, 32'hCAFE_F00D, 32'h7878_7878, 32'h5A5A_5A5A};
        bus_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, addrs[i], wds[i], f3s[i]);
            total++;
            if ({bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata} !==
                {1'b1, 1'b1, addrs[i] & 32'hFFFF_FFFC, strbs[i], reps[i]}) begin
                bad++; $display("FAIL store%0d got=%b%b/%h/%b/%h exp=11/%h/%b/%h", i, bus_valid, bus_we,
                                bus_addr, bus_wstrb, bus_wdata, addrs[i] & 32'hFFFF_FFFC, strbs[i], reps[i]);
            end
            tick();
            total++;
            if ({cpu_done, cpu_err} !== 2'b10) begin
                bad++; $display("FAIL store%0d_done got=%b exp=10", i, {cpu_done, cpu_err});
            end
            tick();
        end
    endtask

    task automatic test_loads();
        logic [31:0] addrs [11] = '{32'h2002, 32'h2002, 32'h2001, 32'h2001, 32'h2000, 32'h2003,
                                   32'h2002, 32'h2002, 32'h2000, 32'h2000, 32'h2004};
        logic [2:0]  f3s   [11] = '{F3_B, F3_BU, F3_B, F3_BU, F3_B, F3_B, F3_H, F3_HU, F3_H, F3_HU, F3_W};
        logic [31:0] rds   [11] = '{32'h0080_FF00, 32'h0080_FF00, 32'h0080_FF00, 32'h0080_FF00, 32'h1234_56F0,
                                   32'h9A00_0000, 32'h8001_1234, 32'h8001_1234, 32'h8001_1234, 32'h1234_FFFE,
                                   32'hDEAD_BEEF};
        logic [31:0] exps  [11] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FFF0,
                                   32'hFFFF_FF9A, 32'hFFFF_8001, 32'h0000_8001, 32'h0000_1234, 32'h0000_FFFE,
                                   32'hDEAD_BEEF};
        bus_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            issue(1'b0, addrs[i], 32'hFFFF_FFFF, f3s[i]);
            total++;
            if ({bus_valid, bus_we, bus_wstrb, bus_addr} !== {1'b1, 1'b0, 4'b0000, addrs[i] & 32'hFFFF_FFFC}) begin
                bad++; $display("FAIL load%0d_req got=%b%b/%b/%h exp=10/0000/%h", i, bus_valid, bus_we,
                                bus_wstrb, bus_addr, addrs[i] & 32'hFFFF_FFFC);
            end
            tick();
            bus_rvalid = 1'b1;
            bus_rdata  = rds[i];
            tick();
            bus_rvalid = 1'b0;
            total++;
            if ({cpu_done, cpu_err, cpu_rdata} !== {2'b10, exps[i]}) begin
                bad++; $display("FAIL load%0d got=%b/%h exp=10/%h", i, {cpu_done, cpu_err}, cpu_rdata, exps[i]);
            end
            tick();
        end
    endtask

    task automatic test_errors();
        logic        wes   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] addrs [9] = '{32'h2001, 32'h2001, 32'h2000, 32'h2000, 32'h2001, 32'h2003,
                                   32'h2002, 32'h2000, 32'h2000};
        logic [2:0]  f3s   [9] = '{F3_W, F3_H, 3'b100, 3'b101, F3_H, F3_HU, F3_W, 3'b011, 3'b111};
        logic [31:0] exps  [9] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                                   32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        bus_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            issue(wes[i], addrs[i], 32'h1111_1111, f3s[i]);
            total++;
            if ({cpu_done, cpu_err, bus_valid, cpu_rdata} !== {3'b110, exps[i]}) begin
                bad++; $display("FAIL err%0d got=%b/%h exp=110/%h", i, {cpu_done, cpu_err, bus_valid}, cpu_rdata, exps[i]);
            end
            tick();
            total++;
            if ({cpu_done, cpu_busy, bus_valid} !== 3'b000) begin
                bad++; $display("FAIL err%0d_after got=%b exp=000", i, {cpu_done, cpu_busy, bus_valid});
            end
        end
    endtask

    task automatic test_wait_states();
        bus_ready = 1'b0;
        issue(1'b0, 32'h0000_4008, 32'h0, F3_W);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus_ready = 1'b1;
            total++;
            if ({bus_valid, bus_we, cpu_busy, cpu_done, bus_addr} !== {4'b1010, 32'h0000_4008}) begin
                bad++; $display("FAIL wait_addr%0d got=%b/%h exp=1010/00004008", i,
                                {bus_valid, bus_we, cpu_busy, cpu_done}, bus_addr);
            end
            tick();
        end
        bus_ready = 1'b0;
        total++;
        if ({bus_valid, cpu_busy, cpu_done} !== 3'b010) begin
            bad++; $display("FAIL wait_resp1 got=%b exp=010", {bus_valid, cpu_busy, cpu_done});
        end
        tick();
        total++;
        if ({bus_valid, cpu_busy, cpu_done} !== 3'b010) begin
            bad++; $display("FAIL wait_resp2 got=%b exp=010", {bus_valid, cpu_busy, cpu_done});
        end
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEAD_BEEF;
        tick();
        bus_rvalid = 1'b0;
        total++;
        if ({cpu_done, cpu_err, cpu_busy, cpu_rdata} !== {3'b101, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL wait_done got=%b/%h exp=101/deadbeef", {cpu_done, cpu_err, cpu_busy}, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_timeout();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        issue(1'b0, 32'h0000_5000, 32'h0, F3_W);
        total++;
        if ({tAddr, tWe, tWstrb, tWdata} !== {32'h0000_5000, 37'd0}) begin
            bad++; $display("FAIL to_req got=%h/%b/%b/%h exp=00005000/0/0000/0", tAddr, tWe, tWstrb, tWdata);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({tValid, tDone} !== 2'b10) begin
                bad++; $display("FAIL to_wait%0d got=%b exp=10", i, {tValid, tDone});
            end
            tick();
        end
        total++;
        if ({tDone, tErr, tValid, tRdata} !== {3'b110, 32'h0}) begin
            bad++; $display("FAIL to_done got=%b/%h exp=110/0", {tDone, tErr, tValid}, tRdata);
        end
        tick();
        total++;
        if ({tDone, tBusy, tValid} !== 3'b000) begin
            bad++; $display("FAIL to_after got=%b exp=000", {tDone, tBusy, tValid});
        end
        bus_ready = 1'b1;
        issue(1'b0, 32'h0000_5004, 32'h0, F3_W);
        tick();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1122_3344;
        tick();
        bus_rvalid = 1'b0;
        total++;
        if ({tDone, tErr, tRdata} !== {2'b10, 32'h1122_3344}) begin
            bad++; $display("FAIL to_next got=%b/%h exp=10/11223344", {tDone, tErr}, tRdata);
        end
        tick();
        issue(1'b0, 32'h0000_5008, 32'h0, F3_W);
        tick();
        bus_ready = 1'b0;
        tick();
        tick();
        total++;
        if ({tDone, tBusy} !== 2'b01) begin
            bad++; $display("FAIL to_resp_wait got=%b exp=01", {tDone, tBusy});
        end
        tick();
        total++;
        if ({tDone, tErr, tRdata} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL to_resp got=%b/%h exp=11/0", {tDone, tErr}, tRdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        bus_ready = 1'b1;
        issue(1'b0, 32'h0000_6000, 32'h0, F3_W);
        tick();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hA5A5_0001;
        tick();
        bus_rvalid = 1'b0;
        total++;
        if ({cpu_done, cpu_rdata} !== {1'b1, 32'hA5A5_0001}) begin
            bad++; $display("FAIL rst_pre got=%b/%h exp=1/a5a50001", cpu_done, cpu_rdata);
        end
        tick();
        issue(1'b0, 32'h0000_6004, 32'h0, F3_W);
        tick();
        total++;
        if ({cpu_busy, bus_valid} !== 2'b10) begin
            bad++; $display("FAIL rst_inresp got=%b exp=10", {cpu_busy, bus_valid});
        end
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        total++;
        if ({cpu_done, cpu_err, cpu_busy, bus_valid, cpu_rdata, bus_addr} !== 68'd0) begin
            bad++; $display("FAIL rst_resp got=%b/%h/%h exp=0/0/0", {cpu_done, cpu_err, cpu_busy, bus_valid},
                            cpu_rdata, bus_addr);
        end
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({cpu_done, cpu_busy, cpu_rdata} !== 34'd0) begin
                bad++; $display("FAIL rst_stale%0d got=%b/%h exp=00/0", i, {cpu_done, cpu_busy}, cpu_rdata);
            end
        end
        bus_rvalid = 1'b0;
        bus_ready  = 1'b0;
        issue(1'b1, 32'h0000_6008, 32'h1234_5678, F3_W);
        total++;
        if ({bus_valid, bus_wstrb} !== 5'b11111) begin
            bad++; $display("FAIL rst_addr_pre got=%b exp=11111", {bus_valid, bus_wstrb});
        end
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        total++;
        if ({bus_valid, bus_we, bus_wstrb, cpu_busy} !== 7'd0) begin
            bad++; $display("FAIL rst_addr got=%b exp=0000000", {bus_valid, bus_we, bus_wstrb, cpu_busy});
        end
        bus_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        bus_ready = 1'b1;
        issue(1'b1, 32'h0000_7100, 32'h0000_0011, F3_W);
        tick();
        cpu_req    = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 32'h0000_7000;
        cpu_wdata  = 32'h0000_0022;
        cpu_funct3 = F3_W;
        total++;
        if (cpu_done !== 1'b1) begin
            bad++; $display("FAIL b2b_done1 got=%b exp=1", cpu_done);
        end
        tick();
        total++;
        if ({cpu_done, cpu_busy, bus_valid} !== 3'b000) begin
            bad++; $display("FAIL b2b_idle got=%b exp=000", {cpu_done, cpu_busy, bus_valid});
        end
        tick();
        cpu_req = 1'b0;
        total++;
        if ({bus_valid, bus_addr, bus_wdata} !== {1'b1, 32'h0000_7000, 32'h0000_0022}) begin
            bad++; $display("FAIL b2b_addr got=%b/%h/%h exp=1/00007000/00000022", bus_valid, bus_addr, bus_wdata);
        end
        tick();
        total++;
        if ({cpu_done, cpu_err} !== 2'b10) begin
            bad++; $display("FAIL b2b_done2 got=%b exp=10", {cpu_done, cpu_err});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_sb();
        test_stores();
        test_loads();
        test_errors();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
